// File: rtl/var_bw_mul_seq_if.sv
// Operand/product handshake bundle for var_bw_mul_seq.
// A beat moves on either side only in a cycle where valid and ready are both high at the rising edge.
interface var_bw_mul_seq_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           mode_err;

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, p, mode_err
  );

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, p, mode_err
  );
endinterface

// File: rtl/var_bw_mul_seq.sv
// Sequential lane-split shift-add multiplier: 1x W, 2x W/2 or 4x W/4 unsigned lanes.
// One multiplier bit per lane per BUSY cycle; lanes never exchange carries.
module var_bw_mul_seq #(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  var_bw_mul_seq_if.slave   io_bus,
  output logic [1:0]        o_dbg_state
);
  localparam int CW = $clog2(W + 1);
  localparam int L2 = W / 2;
  localparam int L4 = W / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_mode;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_p;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_mode_err;

  logic [CW-1:0]  w_len;
  logic [W-1:0]   w_bsh;
  logic [2*W-1:0] w_acc_next;

  // Lane k-th multiplier bits all land at bit i*L of the shifted operand.
  assign w_bsh = r_b >> r_cnt;

  always_comb begin
    w_len = CW'(W);
    case (r_mode)
      2'b01:   w_len = CW'(L2);
      2'b10:   w_len = CW'(L4);
      default: w_len = CW'(W);
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    case (r_mode)
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          if (w_bsh[i*L2])
            w_acc_next[i*W +: W] = r_acc[i*W +: W] + ({{L2{1'b0}}, r_a[i*L2 +: L2]} << r_cnt);
        end
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          if (w_bsh[i*L4])
            w_acc_next[i*L2 +: L2] = r_acc[i*L2 +: L2] + ({{L4{1'b0}}, r_a[i*L4 +: L4]} << r_cnt);
        end
      end
      default: begin
        if (w_bsh[0])
          w_acc_next = r_acc + ({{W{1'b0}}, r_a} << r_cnt);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 2'b00;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mode_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            r_a        <= io_bus.a;
            r_b        <= io_bus.b;
            r_mode     <= io_bus.mode;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Reserved mode 11 falls through the default lane layout (single W lane).
          if (r_cnt == w_len) begin
            r_p         <= r_acc;
            r_mode_err  <= (r_mode == 2'b11);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.p         = r_p;
  assign io_bus.mode_err  = r_mode_err;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_var_bw_mul_seq.sv
// Bench for var_bw_mul_seq: directed corner cases then random ops with random sink stalls,
// scored against a lane-wise arithmetic product model.
module tb_var_bw_mul_seq;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  var_bw_mul_seq_if #(.W(W)) bus ();

  var_bw_mul_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [2*W-1:0] p;
    logic           err;
    int             acc;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   force_ready = 1;
  bit   lat_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: each lane is an independent unsigned L x L -> 2L product.
  function automatic logic [2*W-1:0] ref_mul(input logic [1:0] m, input logic [W-1:0] av,
                                             input logic [W-1:0] bv);
    int L;
    longint unsigned mask, x, y, r;
    L = (m == 2'b01) ? W/2 : (m == 2'b10) ? W/4 : W;
    mask = (64'd1 << L) - 64'd1;
    r = 0;
    for (int i = 0; i < W/L; i++) begin
      x = (64'(av) >> (i*L)) & mask;
      y = (64'(bv) >> (i*L)) & mask;
      r = r | ((x * y) << (2*L*i));
    end
    return (2*W)'(r);
  endfunction

  function automatic int lane_len(input logic [1:0] m);
    return (m == 2'b01) ? W/2 : (m == 2'b10) ? W/4 : W;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [2*W-1:0] ep, input logic ee, input int lat);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.a = av;
    bus.b = bv;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(t), 64'(0));
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{p: ep, err: ee, acc: cyc + 1, lat: lat});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.mode = 2'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_p"},         64'(bus.p),         64'(0));
    chk({tag, "_mode_err"},  64'(bus.mode_err),  64'(0));
    chk({tag, "_state"},     64'(dbg_state),     64'(0));
  endtask

  // Sink ready changes just after the rising edge so the monitor sees a settled value.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (force_ready < 0) ? ($urandom_range(0, 3) != 0) : (force_ready != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_seen = 1'b0;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          if (!lat_seen) begin
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
            lat_seen = 1'b1;
          end
          chk("p", 64'(bus.p), 64'(exp_q[0].p));
          chk("mode_err", 64'(bus.mode_err), 64'(exp_q[0].err));
          chk("in_ready_done", 64'(bus.in_ready), 64'(0));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            lat_seen = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   m;
    logic [W-1:0] av, bv;
    int           t;

    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_released");

    force_ready = 1;
    send(2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17);
    wait_drain(100);
    send(2'b01, 16'h0A03, 16'h0B05, 32'h006E_000F, 1'b0, 9);
    wait_drain(100);
    send(2'b10, 16'hFFFF, 16'hFFFF, 32'hE1E1_E1E1, 1'b0, 5);
    wait_drain(100);

    // Backpressure in DONE with stray operand beats that must not be taken.
    force_ready = 0;
    send(2'b10, 16'h1234, 16'h5678, 32'h050C_1520, 1'b0, 5);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reached_done", 64'(bus.out_valid), 64'(1));
    chk("stall_state", 64'(dbg_state), 64'(2));
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    force_ready = 1;
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("no_stray_accept", 64'(dbg_state), 64'(0));

    // Asynchronous reset in the middle of BUSY drops the operation.
    av = W'($urandom);
    bv = W'($urandom);
    send(2'b00, av, bv, ref_mul(2'b00, av, bv), 1'b0, 17);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_reset_p", 64'(bus.p), 64'(0));
    chk("mid_reset_in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_reset_state", 64'(dbg_state), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    send(2'b11, 16'd3, 16'd5, 32'h0000_000F, 1'b1, 17);
    wait_drain(100);

    // Random operations with random sink stalls.
    force_ready = -1;
    for (int i = 0; i < 1000; i++) begin
      m = 2'($urandom_range(0, 3));
      av = W'($urandom);
      bv = W'($urandom);
      send(m, av, bv, ref_mul(m, av, bv), (m == 2'b11), lane_len(m) + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain(2000);
    force_ready = 1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
